// File: rtl/bus_matrix_slave_arbiter.sv
// Per-slave round-robin arbiter for the bus matrix: grants one requesting master the slave port,
// honours locked sequences, and optionally revokes a grant held too long.
module bus_matrix_slave_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 0,
  parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [N_MASTERS-1:0] lock_i,
  input  logic                 done_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int                HC_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [HC_W-1:0]   HOLD_MAX  = {HC_W{1'b1}};
  localparam logic              WD_EN     = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= N_MASTERS - 1) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_MASTERS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Returns {found, index}: first set request scanning upward from ptr with wrap.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                             input logic [IDX_W-1:0]     ptr);
    logic             found;
    logic [IDX_W-1:0] win;
    int               k;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      k = int'(ptr) + i;
      if (k >= N_MASTERS) begin
        k = k - N_MASTERS;
      end else begin
        k = k;
      end
      if (!found && req[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HC_W-1:0]      hold_q, hold_d;

  logic                 owner_req_s, owner_lock_s;
  logic                 rel_done_s, rel_aband_s, rel_to_s, release_s;
  logic [IDX_W:0]       pick_idle_s, pick_rel_s;

  // Release conditions and both arbitration candidates (from rr_ptr, and owner-masked after release).
  always_comb begin
    owner_req_s  = req_i[idx_q];
    owner_lock_s = lock_i[idx_q];
    rel_done_s   = done_i & ~owner_lock_s;
    rel_aband_s  = ~owner_req_s;
    rel_to_s     = WD_EN & (hold_q == HOLD_LAST) & ~rel_done_s & ~rel_aband_s;
    release_s    = rel_done_s | rel_aband_s | rel_to_s;
    pick_idle_s  = rr_pick(req_i, rr_ptr_q);
    pick_rel_s   = rr_pick(req_i & ~onehot(idx_q), next_idx(idx_q));
  end

  // Next-state logic for the IDLE/GRANT machine and all registered outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (pick_idle_s[IDX_W]) begin
          state_d = ST_GRANT;
          idx_d   = pick_idle_s[IDX_W-1:0];
          gnt_d   = onehot(pick_idle_s[IDX_W-1:0]);
          busy_d  = 1'b1;
        end else begin
          gnt_d  = '0;
          idx_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          rr_ptr_d  = next_idx(idx_q);
          timeout_d = rel_to_s;
          hold_d    = '0;
          // Hand over directly when another master waits, avoiding an idle bubble.
          if (pick_rel_s[IDX_W]) begin
            state_d = ST_GRANT;
            idx_d   = pick_rel_s[IDX_W-1:0];
            gnt_d   = onehot(pick_rel_s[IDX_W-1:0]);
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (done_i && owner_lock_s) begin
          hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HC_W'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
